// File: rtl/ms_timer_pkg.sv
// Shared helpers and encodings for the millisecond stopwatch array.
// Tick period arithmetic and the wrap/saturate mode selector live here.
package ms_timer_pkg;

    localparam int MODE_SATURATE = 0;
    localparam int MODE_WRAP     = 1;

    function automatic int tick_cnt(input int clkspdmhz, input int tick_us);
        return clkspdmhz * tick_us;
    endfunction

    function automatic int presc_w(input int tc);
        return $clog2(tc);
    endfunction

endpackage

// File: rtl/ms_timer_channel.sv
// One stopwatch channel: run control, prescaler, elapsed counter, overflow and lap capture.
// All outputs are registered; clear dominates start, which dominates stop.
module ms_timer_channel
    import ms_timer_pkg::*;
#(
    parameter int TICK_CNT  = 100000,
    parameter int WIDTH     = 16,
    parameter int MAX_COUNT = 9999,
    parameter int WRAP_MODE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             lap,
    output logic [WIDTH-1:0] elapsed,
    output logic [WIDTH-1:0] lap_value,
    output logic             lap_valid,
    output logic             running,
    output logic             overflow
);

    localparam int               PW         = presc_w(TICK_CNT);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_CNT - 1);
    localparam logic [WIDTH-1:0] MAXV       = WIDTH'(MAX_COUNT);

    logic [PW-1:0] presc;
    logic          tick;
    logic          at_max;
    logic          sat_stop;

    assign tick     = running && (presc == PRESC_LAST);
    assign at_max   = (elapsed == MAXV);
    assign sat_stop = tick && at_max && (WRAP_MODE != MODE_WRAP);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            running   <= 1'b0;
            presc     <= '0;
            elapsed   <= '0;
            overflow  <= 1'b0;
            lap_value <= '0;
            lap_valid <= 1'b0;
        end else if (clear) begin
            // lap_value survives a clear so the last captured time stays on display
            running   <= 1'b0;
            presc     <= '0;
            elapsed   <= '0;
            overflow  <= 1'b0;
            lap_valid <= 1'b0;
        end else begin
            lap_valid <= lap;
            if (lap)
                lap_value <= elapsed;

            if (running)
                presc <= tick ? '0 : presc + PW'(1);

            if (tick) begin
                if (!at_max) begin
                    elapsed <= elapsed + WIDTH'(1);
                end else begin
                    overflow <= 1'b1;
                    if (WRAP_MODE == MODE_WRAP)
                        elapsed <= '0;
                end
            end

            // A running channel ignores start, so saturation stops it even if start is held
            if (!running)
                running <= start;
            else if (sat_stop || (stop && !start))
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/ms_timer_array.sv
// N_CH independent millisecond stopwatches with packed output buses.
// Channel i occupies bits [i*WIDTH +: WIDTH] of elapsed and lap_value.
module ms_timer_array
    import ms_timer_pkg::*;
#(
    parameter int CLKSPDMHZ = 100,
    parameter int TICK_US   = 1000,
    parameter int N_CH      = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_COUNT = 9999,
    parameter int WRAP_MODE = MODE_WRAP
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       stop,
    input  logic [N_CH-1:0]       clear,
    input  logic [N_CH-1:0]       lap,
    output logic [N_CH*WIDTH-1:0] elapsed,
    output logic [N_CH*WIDTH-1:0] lap_value,
    output logic [N_CH-1:0]       lap_valid,
    output logic [N_CH-1:0]       running,
    output logic [N_CH-1:0]       overflow
);

    localparam int TC = tick_cnt(CLKSPDMHZ, TICK_US);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ms_timer_channel #(
            .TICK_CNT  (TC),
            .WIDTH     (WIDTH),
            .MAX_COUNT (MAX_COUNT),
            .WRAP_MODE (WRAP_MODE)
        ) u_ch (
            .clk       (clk),
            .res       (res),
            .start     (start[i]),
            .stop      (stop[i]),
            .clear     (clear[i]),
            .lap       (lap[i]),
            .elapsed   (elapsed[i*WIDTH +: WIDTH]),
            .lap_value (lap_value[i*WIDTH +: WIDTH]),
            .lap_valid (lap_valid[i]),
            .running   (running[i]),
            .overflow  (overflow[i])
        );
    end

endmodule
